// File: rtl/spi_apb_sequencer.sv
// APB2 master that sequences the SPI controller's control write, per-byte
// data write, receive poll and data read for a byte-stream transfer.
module spi_apb_sequencer #(
    parameter logic [3:0]  CTRL_ADDR  = 4'h0,
    parameter logic [3:0]  DATA_ADDR  = 4'h8,
    parameter logic [7:0]  CTRL_VALUE = 8'h00,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       start,
    input  logic [7:0] len_m1,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [3:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       tx_reg_empty,
    input  logic       rx_data_ready
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TO_W  = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, CFG_SETUP, CFG_ACCESS, WAIT_TX, TX_SETUP, TX_ACCESS,
        WAIT_RX, RX_SETUP, RX_ACCESS, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             busy_d, done_d, error_d, rx_valid_d;
    logic             psel_d, penable_d, pwrite_d;
    logic [3:0]       paddr_d;
    logic [7:0]       pwdata_d, rx_data_d;

    // Handshake must follow tx_reg_empty in the same cycle the byte is offered.
    assign tx_ready = (state_q == WAIT_TX) && tx_reg_empty;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        error_d    = error;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data;
        pwrite_d   = PWRITE;
        paddr_d    = PADDR;
        pwdata_d   = PWDATA;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = len_m1;
                    byte_cnt_d = '0;
                    error_d    = 1'b0;
                    state_d    = CFG_SETUP;
                end
            end
            CFG_SETUP:  state_d = CFG_ACCESS;
            CFG_ACCESS: state_d = WAIT_TX;
            WAIT_TX: begin
                if (tx_reg_empty) begin
                    if (tx_valid) begin
                        pwdata_d = tx_data;
                        state_d  = TX_SETUP;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            TX_SETUP:  state_d = TX_ACCESS;
            TX_ACCESS: state_d = WAIT_RX;
            WAIT_RX: begin
                if (rx_data_ready) begin
                    state_d = RX_SETUP;
                end else if (to_cnt_q == TO_LAST) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            RX_SETUP: state_d = RX_ACCESS;
            RX_ACCESS: begin
                rx_data_d  = PRDATA;
                rx_valid_d = 1'b1;
                if (byte_cnt_q == len_q) begin
                    state_d = DONE;
                end else begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    state_d    = WAIT_TX;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            to_cnt_d = '0;
        end

        // Address phase fields are loaded on entry to a SETUP state and held otherwise.
        case (state_d)
            CFG_SETUP: begin
                paddr_d  = CTRL_ADDR;
                pwrite_d = 1'b1;
                pwdata_d = CTRL_VALUE;
            end
            TX_SETUP: begin
                paddr_d  = DATA_ADDR;
                pwrite_d = 1'b1;
            end
            RX_SETUP: begin
                paddr_d  = DATA_ADDR;
                pwrite_d = 1'b0;
            end
            default: ;
        endcase

        psel_d    = state_d inside {CFG_SETUP, CFG_ACCESS, TX_SETUP, TX_ACCESS, RX_SETUP, RX_ACCESS};
        penable_d = state_d inside {CFG_ACCESS, TX_ACCESS, RX_ACCESS};
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        done_d    = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q    <= IDLE;
            to_cnt_q   <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            rx_valid   <= rx_valid_d;
            rx_data    <= rx_data_d;
            PSEL       <= psel_d;
            PENABLE    <= penable_d;
            PWRITE     <= pwrite_d;
            PADDR      <= paddr_d;
            PWDATA     <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Bench for spi_apb_sequencer: SPI controller register model, APB phase
// monitor and expected-access/expected-byte queues.
module tb_spi_apb_sequencer;

    localparam logic [3:0] CTRL_A = 4'h0;
    localparam logic [3:0] DATA_A = 4'h8;
    localparam logic [7:0] CTRL_V = 8'h5A;
    localparam int unsigned TO    = 16;

    logic       PCLK, PRESETN, start, busy, done, error, tx_valid, tx_ready;
    logic       rx_valid, PSEL, PENABLE, PWRITE, tx_reg_empty, rx_data_ready;
    logic [7:0] len_m1, tx_data, rx_data, PWDATA, PRDATA;
    logic [3:0] PADDR;

    spi_apb_sequencer #(
        .CTRL_ADDR(CTRL_A), .DATA_ADDR(DATA_A), .CTRL_VALUE(CTRL_V), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .start(start), .len_m1(len_m1),
        .busy(busy), .done(done), .error(error),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA),
        .tx_reg_empty(tx_reg_empty), .rx_data_ready(rx_data_ready)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct { logic [3:0] addr; logic wr; logic [7:0] data; int cyc; } apb_t;
    apb_t       apb_obs[$];
    apb_t       apb_exp[$];
    logic [7:0] rx_obs[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_bytes [256];

    int checks = 0;
    int errors = 0;
    int cyc_n = 0, busy_cyc = 0, done_cnt = 0, bad = 0, setup_cyc = 0;
    bit p_sel, p_en, p_wr;
    logic [3:0] p_addr;
    logic [7:0] p_data;

    bit         loopback = 1'b1;
    bit         rx_en = 1'b1;
    logic [7:0] fixed_rd = 8'h3C;
    logic [7:0] hold;

    // SPI controller register model: a data write makes a byte ready, a read consumes it.
    always @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            rx_data_ready <= 1'b0;
            hold          <= 8'h00;
        end else if (PSEL && PENABLE && PWRITE && PADDR == DATA_A) begin
            hold          <= PWDATA;
            rx_data_ready <= rx_en;
        end else if (PSEL && PENABLE && !PWRITE) begin
            rx_data_ready <= 1'b0;
        end
    end
    assign PRDATA = loopback ? hold : fixed_rd;

    // Monitor: records completed accesses and counts APB phase violations.
    always @(negedge PCLK) begin
        cyc_n++;
        if (!PRESETN) begin
            p_sel = 1'b0;
            p_en  = 1'b0;
        end else begin
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (rx_valid) rx_obs.push_back(rx_data);
            if (tx_ready && PSEL) bad++;
            if (PENABLE && !PSEL) bad++;
            if (PSEL && !PENABLE) begin
                if (p_sel) bad++;
                setup_cyc = cyc_n;
            end
            if (PSEL && PENABLE) begin
                if (!(p_sel && !p_en) || PADDR !== p_addr || PWRITE !== p_wr || PWDATA !== p_data) bad++;
                apb_obs.push_back('{PADDR, PWRITE, PWRITE ? PWDATA : PRDATA, setup_cyc});
            end
            p_sel = PSEL; p_en = PENABLE; p_wr = PWRITE; p_addr = PADDR; p_data = PWDATA;
        end
    end

    task automatic clear_sb();
        apb_obs.delete(); apb_exp.delete(); rx_obs.delete(); rx_exp.delete();
        busy_cyc = 0; done_cnt = 0; bad = 0;
    endtask

    task automatic do_reset();
        @(negedge PCLK); #1;
        PRESETN = 1'b0;
        repeat (2) @(negedge PCLK);
        #1 PRESETN = 1'b1;
    endtask

    // Starts a transfer, feeds tx_bytes and pushes the expected accesses as bytes are accepted.
    task automatic run_xfer(input int nbytes, input int stall_cyc, input bit exp_rx,
                            output bit timed_out, output int start_cyc);
        int idx = 0;
        int stall = stall_cyc;
        timed_out = 1'b1;
        @(negedge PCLK); #1;
        clear_sb();
        len_m1    = 8'(nbytes - 1);
        start     = 1'b1;
        start_cyc = cyc_n;
        apb_exp.push_back('{CTRL_A, 1'b1, CTRL_V, 0});
        for (int k = 0; k < 4000; k++) begin
            @(negedge PCLK); #1;
            if (k == 0) start = 1'b0;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (stall > 0) begin
                tx_valid = 1'b0;
                stall--;
            end else begin
                tx_valid = (idx < nbytes);
                if (idx < nbytes) tx_data = tx_bytes[idx];
            end
            #1;
            if (tx_valid && tx_ready) begin
                apb_exp.push_back('{DATA_A, 1'b1, tx_data, 0});
                if (exp_rx) begin
                    apb_exp.push_back('{DATA_A, 1'b0, 8'h00, 0});
                    rx_exp.push_back(loopback ? tx_data : fixed_rd);
                end
                idx++;
            end
        end
        tx_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, error, tx_ready, rx_valid, PSEL, PENABLE, PWRITE} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {busy, done, error, tx_ready, rx_valid, PSEL, PENABLE, PWRITE});
        end
        checks++;
        if ({PADDR, PWDATA, rx_data} !== 20'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rx=%h expected 0", PADDR, PWDATA, rx_data);
        end
    endtask

    task automatic test_single();
        bit to; int sc; apb_t e, o; logic [7:0] re, ro;
        loopback = 1'b0;
        tx_bytes[0] = 8'hA5;
        run_xfer(1, 0, 1'b1, to, sc);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL single_timeout: got no done expected done"); end
        checks++;
        if (apb_obs.size() > 0 && apb_obs[0].cyc !== sc + 1) begin
            errors++; $display("FAIL single_latency: got %0d expected %0d", apb_obs[0].cyc, sc + 1);
        end
        checks++;
        if (apb_obs.size() !== apb_exp.size()) begin
            errors++; $display("FAIL single_apb_count: got %0d expected %0d", apb_obs.size(), apb_exp.size());
        end
        while (apb_exp.size() > 0 && apb_obs.size() > 0) begin
            e = apb_exp.pop_front(); o = apb_obs.pop_front(); checks++;
            if (o.addr !== e.addr || o.wr !== e.wr || (e.wr && o.data !== e.data)) begin
                errors++;
                $display("FAIL single_apb: got a=%h w=%b d=%h expected a=%h w=%b d=%h",
                         o.addr, o.wr, o.data, e.addr, e.wr, e.data);
            end
        end
        checks++;
        if (rx_obs.size() !== 1) begin errors++; $display("FAIL single_rx_count: got %0d expected 1", rx_obs.size()); end
        if (rx_obs.size() > 0 && rx_exp.size() > 0) begin
            re = rx_exp.pop_front(); ro = rx_obs.pop_front(); checks++;
            if (ro !== re) begin errors++; $display("FAIL single_rx: got %h expected %h", ro, re); end
        end
        checks++;
        if (done_cnt !== 1 || error !== 1'b0 || busy_cyc !== 8 || bad !== 0) begin
            errors++;
            $display("FAIL single_status: got done=%0d err=%b busy=%0d bad=%0d expected 1 0 8 0",
                     done_cnt, error, busy_cyc, bad);
        end
        loopback = 1'b1;
    endtask

    task automatic test_max_burst();
        bit to; int sc; apb_t e, o; logic [7:0] re, ro; int apb_bad = 0; int rx_bad = 0;
        for (int i = 0; i < 256; i++) tx_bytes[i] = 8'(i + 3);
        run_xfer(256, 0, 1'b1, to, sc);
        checks++;
        if (to !== 1'b0 || done_cnt !== 1) begin
            errors++; $display("FAIL burst_done: got to=%b done=%0d expected 0 1", to, done_cnt);
        end
        checks++;
        if (apb_obs.size() !== 513 || rx_obs.size() !== 256) begin
            errors++; $display("FAIL burst_count: got apb=%0d rx=%0d expected 513 256", apb_obs.size(), rx_obs.size());
        end
        while (apb_exp.size() > 0 && apb_obs.size() > 0) begin
            e = apb_exp.pop_front(); o = apb_obs.pop_front(); checks++;
            if (o.addr !== e.addr || o.wr !== e.wr || (e.wr && o.data !== e.data)) begin
                errors++; apb_bad++;
                if (apb_bad < 5) $display("FAIL burst_apb: got a=%h w=%b d=%h expected a=%h w=%b d=%h",
                                          o.addr, o.wr, o.data, e.addr, e.wr, e.data);
            end
        end
        while (rx_exp.size() > 0 && rx_obs.size() > 0) begin
            re = rx_exp.pop_front(); ro = rx_obs.pop_front(); checks++;
            if (ro !== re) begin
                errors++; rx_bad++;
                if (rx_bad < 5) $display("FAIL burst_rx: got %h expected %h", ro, re);
            end
        end
        checks++;
        if (bad !== 0 || busy_cyc !== 1538 || error !== 1'b0) begin
            errors++; $display("FAIL burst_timing: got bad=%0d busy=%0d err=%b expected 0 1538 0", bad, busy_cyc, error);
        end
    endtask

    task automatic test_tx_stall();
        bit to; int sc; int gap;
        tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22;
        run_xfer(2, 50, 1'b1, to, sc);
        gap = (apb_obs.size() >= 2) ? apb_obs[1].cyc - apb_obs[0].cyc : -1;
        checks++;
        if (gap !== 51) begin errors++; $display("FAIL stall_gap: got %0d expected 51", gap); end
        checks++;
        if (to !== 1'b0 || error !== 1'b0 || done_cnt !== 1 || rx_obs.size() !== 2) begin
            errors++; $display("FAIL stall_status: got to=%b err=%b done=%0d rx=%0d expected 0 0 1 2",
                               to, error, done_cnt, rx_obs.size());
        end
        checks++;
        if (rx_obs.size() == 2 && (rx_obs[0] !== rx_exp[0] || rx_obs[1] !== rx_exp[1])) begin
            errors++; $display("FAIL stall_rx: got %h %h expected %h %h", rx_obs[0], rx_obs[1], rx_exp[0], rx_exp[1]);
        end
    endtask

    task automatic test_tx_timeout();
        bit to; int sc;
        tx_reg_empty = 1'b0;
        tx_bytes[0] = 8'h44;
        run_xfer(1, 0, 1'b1, to, sc);
        tx_reg_empty = 1'b1;
        checks++;
        if (to !== 1'b0 || error !== 1'b1 || done_cnt !== 1 || busy_cyc !== 18 || apb_obs.size() !== 1) begin
            errors++; $display("FAIL tx_timeout: got to=%b err=%b done=%0d busy=%0d apb=%0d expected 0 1 1 18 1",
                               to, error, done_cnt, busy_cyc, apb_obs.size());
        end
    endtask

    task automatic test_rx_timeout();
        bit to; int sc;
        rx_en = 1'b0;
        tx_bytes[0] = 8'h96;
        run_xfer(1, 0, 1'b0, to, sc);
        rx_en = 1'b1;
        checks++;
        if (to !== 1'b0 || error !== 1'b1 || done_cnt !== 1 || busy_cyc !== 21) begin
            errors++; $display("FAIL rx_timeout: got to=%b err=%b done=%0d busy=%0d expected 0 1 1 21",
                               to, error, done_cnt, busy_cyc);
        end
        checks++;
        if (apb_obs.size() !== 2 || rx_obs.size() !== 0 || (apb_obs.size() == 2 && apb_obs[1].wr !== 1'b1)) begin
            errors++; $display("FAIL rx_timeout_apb: got apb=%0d rx=%0d expected 2 0", apb_obs.size(), rx_obs.size());
        end
        tx_bytes[0] = 8'h69;
        run_xfer(1, 0, 1'b1, to, sc);
        checks++;
        if (to !== 1'b0 || error !== 1'b0 || rx_obs.size() !== 1 || (rx_obs.size() == 1 && rx_obs[0] !== 8'h69)) begin
            errors++; $display("FAIL rx_timeout_recover: got to=%b err=%b rx=%0d expected 0 0 1", to, error, rx_obs.size());
        end
    endtask

    task automatic test_start_busy();
        bit to; int sc;
        for (int i = 0; i < 4; i++) tx_bytes[i] = 8'hC0 + 8'(i);
        fork
            run_xfer(4, 0, 1'b1, to, sc);
            begin
                repeat (10) @(negedge PCLK);
                #1 start = 1'b1; len_m1 = 8'h00;
                @(negedge PCLK);
                #1 start = 1'b0;
            end
        join
        checks++;
        if (to !== 1'b0 || done_cnt !== 1 || rx_obs.size() !== 4 || busy_cyc !== 26) begin
            errors++; $display("FAIL start_busy: got to=%b done=%0d rx=%0d busy=%0d expected 0 1 4 26",
                               to, done_cnt, rx_obs.size(), busy_cyc);
        end
        checks++;
        if (rx_obs.size() == 4 && rx_obs[3] !== 8'hC3) begin
            errors++; $display("FAIL start_busy_rx: got %h expected c3", rx_obs[3]);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0; bit to; int sc;
        @(negedge PCLK); #1;
        tx_valid = 1'b1; tx_data = 8'h77; len_m1 = 8'h01; start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK); #1;
            start = 1'b0;
            if (PSEL && PENABLE && PWRITE && PADDR === DATA_A) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL reset_mid_reach: got no tx access expected one"); end
        #1 PRESETN = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, busy, PWRITE} !== 4'b0000 || PWDATA !== 8'h00 || PADDR !== 4'h0) begin
            errors++; $display("FAIL reset_mid_async: got sel=%b en=%b busy=%b wr=%b wd=%h a=%h expected 0",
                               PSEL, PENABLE, busy, PWRITE, PWDATA, PADDR);
        end
        tx_valid = 1'b0;
        @(negedge PCLK); #1 PRESETN = 1'b1;
        tx_bytes[0] = 8'hE7;
        run_xfer(1, 0, 1'b1, to, sc);
        checks++;
        if (to !== 1'b0 || apb_obs.size() !== 3 || rx_obs.size() !== 1 || done_cnt !== 1 || error !== 1'b0) begin
            errors++; $display("FAIL reset_mid_rerun: got to=%b apb=%0d rx=%0d done=%0d err=%b expected 0 3 1 1 0",
                               to, apb_obs.size(), rx_obs.size(), done_cnt, error);
        end
        checks++;
        if (apb_obs.size() == 3 && (apb_obs[0].addr !== CTRL_A || apb_obs[0].data !== CTRL_V ||
                                    apb_obs[0].cyc !== sc + 1 || rx_obs[0] !== 8'hE7)) begin
            errors++; $display("FAIL reset_mid_cfg: got a=%h d=%h cyc=%0d rx=%h expected %h %h %0d e7",
                               apb_obs[0].addr, apb_obs[0].data, apb_obs[0].cyc, rx_obs[0], CTRL_A, CTRL_V, sc + 1);
        end
    endtask

    initial begin
        PRESETN = 1'b0; start = 1'b0; len_m1 = 8'h00; tx_data = 8'h00;
        tx_valid = 1'b0; tx_reg_empty = 1'b1;
        do_reset();
        test_reset();
        test_single();
        test_max_burst();
        test_tx_stall();
        test_tx_timeout();
        test_rx_timeout();
        test_start_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_apb_sequencer.md
Name: spi_apb_sequencer

Overview:
- APB2 master that drives the SPI controller's register interface. It turns a byte-stream transfer request into the register write/poll/read sequence the controller needs.
- Sits directly upstream of the SPI controller. Its PSEL/PENABLE/PWRITE/PADDR/PWDATA outputs feed the controller; it consumes the controller's PRDATA, tx_reg_empty and rx_data_ready.
- Frees the CPU fabric from byte-level SPI handling, e.g. for flash command/response bursts.

Parameters:
- CTRL_ADDR, 4'h0, APB address of the controller's control register.
- DATA_ADDR, 4'h8, APB address of the controller's TX/RX data register.
- CTRL_VALUE, 8'h00, byte written to CTRL_ADDR at the start of every transfer (mode/enable setting).
- TIMEOUT, 1024, PCLK cycles allowed in any wait state before abort; must be at least 2.

Ports:
- PCLK  in  1  system clock; all logic rises on this edge.
- PRESETN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- len_m1  in  8  transfer length minus one (1..256 bytes); captured on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of transfer.
- error  out  1  sticky timeout flag; cleared on next accepted start.
- tx_data  in  8  next byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  one-cycle accept; a byte transfers when tx_valid and tx_ready are both high.
- rx_data  out  8  received byte; held until the next rx_valid.
- rx_valid  out  1  one-cycle pulse; no backpressure.
- PSEL, PENABLE, PWRITE  out  1 each  APB2 master controls.
- PADDR  out  4  APB address.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- tx_reg_empty  in  1  controller TX register can accept a byte.
- rx_data_ready  in  1  controller holds a received byte.

Behaviour:
- Reset (asynchronous): state IDLE.
  - All outputs 0: busy, done, error, tx_ready, rx_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rx_data.
  - Byte counter and timeout counter cleared.
- APB2 protocol, no PREADY; every access takes 2 cycles.
  - SETUP cycle: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA valid.
  - ACCESS cycle: PSEL=1, PENABLE=1, address and data held.
  - Next cycle: PSEL=0, PENABLE=0.
  - PADDR/PWDATA/PWRITE hold their last values when idle.
- State machine:
  - IDLE: start=1 captures len_m1, clears error, sets busy, goes to CFG_SETUP. start is ignored in all other states.
  - CFG_SETUP -> CFG_ACCESS: write CTRL_VALUE to CTRL_ADDR. Then go to WAIT_TX.
  - WAIT_TX: tx_ready is high while tx_reg_empty=1. When tx_valid=1 in the same cycle, the byte is accepted: PWDATA<=tx_data, go to TX_SETUP. Stalls indefinitely while tx_valid=0 with tx_reg_empty=1. The timeout counts only while tx_reg_empty=0.
  - TX_SETUP -> TX_ACCESS: write the byte to DATA_ADDR. Then go to WAIT_RX.
  - WAIT_RX: wait for rx_data_ready=1, then go to RX_SETUP.
  - RX_SETUP -> RX_ACCESS: read DATA_ADDR. PRDATA is sampled at the end of the ACCESS cycle.
  - After RX_ACCESS: in the following cycle rx_data<=sampled byte and rx_valid=1.
    - If the byte counter equals the captured len_m1, go to DONE; otherwise increment the counter and go to WAIT_TX.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Timeout: one counter, cleared on every state entry.
  - Increments in WAIT_TX (only while tx_reg_empty=0) and in WAIT_RX.
  - On reaching TIMEOUT-1: error=1, go to DONE. done still pulses, and no further APB access is issued.
- Latency:
  - start to first PSEL: 1 cycle.
  - Best-case per-byte cost: 2 (write) + 1 (rx wait, minimum) + 2 (read) + 1 (WAIT_TX) = 6 cycles.
- Counter width: 8 bits, compared against len_m1. len_m1=8'hFF gives 256 bytes with no wrap.
- tx_ready is never high outside WAIT_TX. At most one byte is in flight.
- Mid-transfer reset: APB outputs drop to 0 immediately (asynchronously). Partial transfer state is discarded.

Test Plan:
- Single byte: len_m1=0, tx 8'hA5, controller model returns 8'h3C. Required response:
  - CTRL_ADDR write of CTRL_VALUE.
  - DATA_ADDR write of 8'hA5.
  - DATA_ADDR read.
  - rx_data=8'h3C with rx_valid once, done once, error=0.
- Max burst: len_m1=8'hFF, incrementing tx bytes, loopback model -> 256 rx_valid pulses with matching data, one done, exact APB 2-cycle phase timing on every access.
- TX stall: tx_valid held low 50 cycles with tx_reg_empty=1 -> no APB activity, no timeout, transfer completes normally.
- RX timeout: TIMEOUT=16, rx_data_ready never asserted -> error=1 and done after 16 WAIT_RX cycles, no read issued. A following start clears error.
- Start while busy: second start mid-transfer -> ignored; byte count unchanged.
- Reset mid-transfer: PRESETN low during TX_ACCESS -> PSEL/PENABLE=0 asynchronously, busy=0. Next start runs cleanly from CFG_SETUP.
